// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter
// Shares one sram_driver between two requesters (port 0: serial command
// engine, port 1: pattern/test engine) with round-robin arbitration.
// Sequences drv_start and follows drv_ready through each access.
// Optional watchdog abort: define SRAM_ARB_WATCHDOG_EN.
//
// Handshake: a requester raises reqN with reN/addrN/wdataN and holds them
// until gntN. gntN is a one-cycle pulse meaning the inputs were latched and
// may change. doneN is a one-cycle pulse when the access ends; for reads,
// rdataN is valid from that pulse until the port's next read completes. A
// req still high after done counts as a new request.
module sram_arbiter #(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0,
   input  logic              req1,
   input  logic              re0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic              timeout,
   input  logic              drv_ready,
   output logic              drv_re,
   output logic              drv_start,
   output logic [ADDR_W-1:0] drv_address,
   output logic [DATA_W-1:0] drv_data_write,
   input  logic [DATA_W-1:0] drv_data_read
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_COMPLETE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              port_q, port_d;           // port owning the current access
   logic              last_port_q, last_port_d; // last granted port
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic              drv_start_q, drv_start_d;
   logic              drv_re_q, drv_re_d;
   logic [ADDR_W-1:0] drv_address_q, drv_address_d;
   logic [DATA_W-1:0] drv_data_write_q, drv_data_write_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic grant_ok;   // IDLE with driver ready and someone asking
   logic pick1;      // arbitration result: 1 selects port 1
   logic wd_abort;   // watchdog fires this cycle

   assign grant_ok = (state_q == S_IDLE) && drv_ready && (req0 || req1);
   // Only one requester -> it wins; both -> the one not served last.
   assign pick1    = req1 && (!req0 || !last_port_q);

`ifdef SRAM_ARB_WATCHDOG_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wd_cnt_q, wd_cnt_d;

   // Watchdog count: cleared on entry to WAIT_BUSY, saturating while waiting
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == S_ISSUE) begin
         wd_cnt_d = 8'd0;
      end else if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
                   (wd_cnt_q != 8'hFF)) begin
         wd_cnt_d = wd_cnt_q + 8'd1;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) wd_cnt_q <= 8'd0;
      else       wd_cnt_q <= wd_cnt_d;
   end

   // Abort only when the driver is not making progress this cycle
   assign wd_abort = (wd_cnt_q >= TO_LAST) &&
                     (((state_q == S_WAIT_BUSY) && drv_ready) ||
                      ((state_q == S_WAIT_DONE) && !drv_ready));
`else
   assign wd_abort = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: one access walks ISSUE -> WAIT_BUSY -> WAIT_DONE -> COMPLETE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (grant_ok) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!drv_ready)    state_d = S_WAIT_DONE;
            else if (wd_abort) state_d = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (drv_ready)     state_d = S_COMPLETE;
            else if (wd_abort) state_d = S_IDLE;
         end
         S_COMPLETE:  state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output logic: next values for every registered output
   always_comb begin
      port_d           = port_q;
      last_port_d      = last_port_q;
      gnt0_d           = 1'b0;
      gnt1_d           = 1'b0;
      done0_d          = 1'b0;
      done1_d          = 1'b0;
      timeout_d        = 1'b0;
      drv_start_d      = 1'b0;
      drv_re_d         = drv_re_q;
      drv_address_d    = drv_address_q;
      drv_data_write_d = drv_data_write_q;
      rdata0_d         = rdata0_q;
      rdata1_d         = rdata1_q;
      busy_d           = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (grant_ok) begin
               port_d           = pick1;
               last_port_d      = pick1;
               gnt0_d           = !pick1;
               gnt1_d           = pick1;
               drv_start_d      = 1'b1;   // high during ISSUE only
               drv_re_d         = pick1 ? re1    : re0;
               drv_address_d    = pick1 ? addr1  : addr0;
               drv_data_write_d = pick1 ? wdata1 : wdata0;
            end
         end
         S_WAIT_DONE: begin
            // done lands in COMPLETE together with the captured read data
            if (drv_ready) begin
               done0_d = !port_q;
               done1_d = port_q;
               if (drv_re_q) begin
                  if (port_q) rdata1_d = drv_data_read;
                  else        rdata0_d = drv_data_read;
               end
            end
         end
         default: ;
      endcase
      if (wd_abort) begin
         done0_d   = !port_q;
         done1_d   = port_q;
         timeout_d = 1'b1;
      end
   end

   // Output and context registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         port_q           <= 1'b0;
         last_port_q      <= 1'b1;
         gnt0_q           <= 1'b0;
         gnt1_q           <= 1'b0;
         done0_q          <= 1'b0;
         done1_q          <= 1'b0;
         busy_q           <= 1'b0;
         timeout_q        <= 1'b0;
         drv_start_q      <= 1'b0;
         drv_re_q         <= 1'b0;
         drv_address_q    <= '0;
         drv_data_write_q <= '0;
         rdata0_q         <= '0;
         rdata1_q         <= '0;
      end else begin
         port_q           <= port_d;
         last_port_q      <= last_port_d;
         gnt0_q           <= gnt0_d;
         gnt1_q           <= gnt1_d;
         done0_q          <= done0_d;
         done1_q          <= done1_d;
         busy_q           <= busy_d;
         timeout_q        <= timeout_d;
         drv_start_q      <= drv_start_d;
         drv_re_q         <= drv_re_d;
         drv_address_q    <= drv_address_d;
         drv_data_write_q <= drv_data_write_d;
         rdata0_q         <= rdata0_d;
         rdata1_q         <= rdata1_d;
      end
   end

   assign gnt0           = gnt0_q;
   assign gnt1           = gnt1_q;
   assign done0          = done0_q;
   assign done1          = done1_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign busy           = busy_q;
   assign timeout        = timeout_q;
   assign drv_re         = drv_re_q;
   assign drv_start      = drv_start_q;
   assign drv_address    = drv_address_q;
   assign drv_data_write = drv_data_write_q;

endmodule
